// File: rtl/bram_stream_pkg.sv
// Shared definitions for the BRAM stream master: size codes, lane/step helpers
// and the controller state encoding.
package bram_stream_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'd0;
  localparam logic [1:0] SIZE_HALF    = 2'd1;
  localparam logic [1:0] SIZE_WORD    = 2'd2;
  localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_FIN
  } state_e;

  function automatic logic [3:0] size_be(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 4'b0001;
      SIZE_HALF: return 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_step(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

  // True when the command cannot be issued to the slave at all.
  function automatic logic size_reject(input logic [1:0] size, input logic [1:0] addr_lsb);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return addr_lsb[0];
      SIZE_WORD: return addr_lsb != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bram_stream_fifo.sv
// Two-entry read-data FIFO between the BRAM slave and the m_* stream.
module bram_stream_fifo
  import bram_stream_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  assign full    = count == 2'd2;
  assign empty   = count == 2'd0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array carries no reset; only pointers and count are reset, and the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/bram_stream_master.sv
// Command-driven master for the run-based single-port BRAM slave, bridging
// valid/ready write and read streams and restarting runs after stalls.
module bram_stream_master
  import bram_stream_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [1:0]              cmd_size,
  input  logic                    cmd_write,
  input  logic                    s_valid,
  input  logic [DATA_WIDTH-1:0]   s_data,
  output logic                    s_ready,
  output logic                    m_valid,
  output logic [DATA_WIDTH-1:0]   m_data,
  input  logic                    m_ready,
  output logic                    done,
  output logic                    err,
  output logic                    mem_enable,
  output logic                    mem_wr_en,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_i_data,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   mem_o_data,
  input  logic                    mem_bus_err
);

  localparam int BE_W = DATA_WIDTH / 8;

  state_e                  state;
  logic [1:0]              size_q;
  logic [LEN_WIDTH-1:0]    len_q;
  logic [LEN_WIDTH-1:0]    remaining;
  logic [LEN_WIDTH-1:0]    captured;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [ADDR_WIDTH-1:0]   run_base;
  logic                    err_q;

  logic [ADDR_WIDTH-1:0]   step;
  logic                    active;
  logic                    wr_beat;
  logic                    rd_issue;
  logic                    abort;
  logic                    push;
  logic                    pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [DATA_WIDTH-1:0]   rd_data;

  assign step     = ADDR_WIDTH'(size_step(size_q));
  assign active   = (state == ST_WR) || (state == ST_RD);
  assign wr_beat  = (state == ST_WR) && s_valid && (remaining != '0);
  assign rd_issue = (state == ST_RD) && (captured != len_q) && !fifo_full;
  assign abort    = active && mem_bus_err;

  // Reset gates the enable combinationally so the slave's run offset clears in the same cycle.
  assign mem_enable = !rst && (wr_beat || rd_issue);
  assign s_ready    = !rst && wr_beat;
  assign mem_wr_en  = state == ST_WR;
  assign mem_addr   = run_base;
  assign mem_i_data = (state == ST_WR) ? s_data : '0;
  assign mem_be     = active ? BE_W'(size_be(size_q)) : '0;
  assign cmd_ready  = state == ST_IDLE;
  assign done       = state == ST_FIN;
  assign err        = err_q;

  // The over-issued read at the end of a run never returns mem_ready, so only real beats land here.
  assign push = (state == ST_RD) && mem_enable && mem_ready;
  assign pop  = m_valid && m_ready;

  // NOTE: every output of this block gets a default first so no latch is inferred on any path.
  always_comb begin
    rd_data = mem_o_data;
    case (size_q)
      SIZE_BYTE: rd_data = {{(DATA_WIDTH-8){1'b0}}, mem_o_data[7:0]};
      SIZE_HALF: rd_data = {{(DATA_WIDTH-16){1'b0}}, mem_o_data[15:0]};
      default:   rd_data = mem_o_data;
    endcase
  end

  bram_stream_fifo #(.WIDTH(DATA_WIDTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .push      (push),
    .push_data (rd_data),
    .pop       (pop),
    .pop_data  (m_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign m_valid = !fifo_empty;

  // NOTE: non-blocking assignments throughout; a later assignment in the same branch overrides an earlier one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      size_q    <= SIZE_BYTE;
      len_q     <= '0;
      remaining <= '0;
      captured  <= '0;
      next_addr <= '0;
      run_base  <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (!mem_enable) run_base <= next_addr;

      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            size_q    <= cmd_size;
            len_q     <= cmd_len;
            remaining <= cmd_len;
            captured  <= '0;
            next_addr <= cmd_addr;
            run_base  <= cmd_addr;
            if (size_reject(cmd_size, cmd_addr[1:0])) err_q <= 1'b1;
            else if (cmd_len == '0)                   state <= ST_FIN;
            else                                      state <= cmd_write ? ST_WR : ST_RD;
          end
        end

        ST_WR: begin
          if (mem_bus_err) begin
            state <= ST_IDLE;
            err_q <= 1'b1;
          end else if (wr_beat) begin
            next_addr <= next_addr + step;
            remaining <= remaining - LEN_WIDTH'(1);
            if (remaining == LEN_WIDTH'(1)) state <= ST_FIN;
          end
        end

        ST_RD: begin
          if (mem_bus_err) begin
            state <= ST_IDLE;
            err_q <= 1'b1;
          end else begin
            if (push) begin
              captured  <= captured + LEN_WIDTH'(1);
              next_addr <= next_addr + step;
            end
            if (captured == len_q && fifo_empty) state <= ST_FIN;
          end
        end

        ST_FIN: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_master.sv
// Randomized self-checking bench: behavioural BRAM slave, byte-array memory
// model and expected read queue, plus directed literal checks.
module tb_bram_stream_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic [15:0] cmd_len;
  logic [1:0]  cmd_size;
  logic        cmd_write;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_ready;
  logic        done;
  logic        err;
  logic        mem_enable;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_i_data;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_o_data;
  logic        mem_bus_err;

  bram_stream_master dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_write  (cmd_write),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .done       (done),
    .err        (err),
    .mem_enable (mem_enable),
    .mem_wr_en  (mem_wr_en),
    .mem_addr   (mem_addr),
    .mem_i_data (mem_i_data),
    .mem_be     (mem_be),
    .mem_ready  (mem_ready),
    .mem_o_data (mem_o_data),
    .mem_bus_err(mem_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural slave: run offset advances per enabled cycle, read data appears one cycle later.
  logic [7:0]  bmem    [1024];
  logic [7:0]  ref_mem [1024];
  logic [31:0] sl_off;
  logic [31:0] sl_dat;
  logic        sl_rdy;
  logic [31:0] sl_a;
  int          sl_n;

  function automatic int be_step(input logic [3:0] be);
    if (be == 4'b1111) return 4;
    if (be == 4'b0011) return 2;
    return 1;
  endfunction

  function automatic logic [31:0] slave_read(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = bmem[10'(a + 32'(b))];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < n; b++) v[8*b +: 8] = ref_mem[10'(a + 32'(b))];
    return v;
  endfunction

  assign sl_a       = mem_addr + sl_off;
  assign sl_n       = be_step(mem_be);
  assign mem_ready  = sl_rdy && mem_enable;
  assign mem_o_data = mem_enable ? sl_dat : 32'h0;

  always @(posedge clk) begin
    if (!mem_enable) begin
      sl_off <= '0;
      sl_rdy <= 1'b0;
    end else begin
      if (mem_wr_en) begin
        for (int b = 0; b < 4; b++)
          if (b < sl_n) bmem[10'(sl_a + 32'(b))] <= mem_i_data[8*b +: 8];
      end else begin
        sl_dat <= slave_read(sl_a, sl_n);
      end
      sl_rdy <= 1'b1;
      sl_off <= sl_off + 32'(sl_n);
    end
  end

  // Reference state for the command in flight.
  logic        bus_ok;
  logic [31:0] cur_base;
  logic [31:0] cur_step;
  logic        cur_wr;
  logic [3:0]  exp_be;
  int          beats;
  int          en_cycles;
  logic        prev_en;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  logic [31:0] run_addrs[$];
  logic [31:0] wr_src[$];

  // Per-cycle compare process.
  initial begin
    prev_en = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        prev_en = 1'b0;
      end else begin
        if (!bus_ok) check("no_bus_activity", 32'(mem_enable), 32'h0);
        if (mem_enable) begin
          if (!prev_en) begin
            run_addrs.push_back(mem_addr);
            check("run_start_addr", mem_addr, cur_base + 32'(beats) * cur_step);
          end
          check("mem_be", 32'(mem_be), 32'(exp_be));
          check("mem_wr_en", 32'(mem_wr_en), 32'(cur_wr));
          en_cycles++;
          if (mem_wr_en || mem_ready) beats++;
        end
        if (m_valid && m_ready) begin
          got_q.push_back(m_data);
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_read_beat: got %h expected none", m_data);
          end else begin
            check("m_data", m_data, exp_q.pop_front());
          end
        end
        prev_en = mem_enable;
      end
    end
  end

  // mode: 0 streams always ready, 1 random, 2 write stall / read 1,0,0 ready pattern,
  //       3 bus-error abort, 4 reset during the third read beat.
  task automatic run_cmd(input logic [31:0] addr, input int len, input logic [1:0] size,
                         input logic wr, input int mode);
    logic rej, hs, aborted, got_done, got_err;
    int   step, idx, cyc, stall, ph, mism;
    rej  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'b00);
    step = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    exp_be = (size == 2'd0) ? 4'b0001 : (size == 2'd1) ? 4'b0011 : 4'b1111;
    cur_base = addr;
    cur_step = 32'(step);
    cur_wr   = wr;
    beats    = 0;
    en_cycles = 0;
    run_addrs.delete();
    got_q.delete();
    if (!rej) begin
      for (int i = 0; i < len; i++) begin
        logic [31:0] a;
        logic [31:0] w;
        a = addr + 32'(i * step);
        if (wr) begin
          w = wr_src[i];
          for (int b = 0; b < step; b++) ref_mem[10'(a + 32'(b))] = w[8*b +: 8];
        end else begin
          exp_q.push_back(model_read(a, step));
        end
      end
    end
    bus_ok = !rej && len != 0;

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = 16'(len);
    cmd_size  = size;
    cmd_write = wr;
    #3;
    check("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    @(negedge clk);
    cmd_valid = 1'b0;

    idx = 0; cyc = 0; stall = 0; ph = 0; aborted = 1'b0; got_done = 1'b0; got_err = 1'b0;
    forever begin
      if (mode == 4 && got_q.size() >= 2) begin
        bus_ok = 1'b0;
        rst = 1'b1;
        #3;
        check("reset_drops_enable_same_cycle", 32'(mem_enable), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #3;
        check("after_reset_enable", 32'(mem_enable), 32'h0);
        check("after_reset_m_valid", 32'(m_valid), 32'h0);
        check("after_reset_cmd_ready", 32'(cmd_ready), 32'h1);
        check("after_reset_pulses", {30'h0, done, err}, 32'h0);
        exp_q.delete();
        m_ready = 1'b0;
        return;
      end
      if (wr && !rej && idx < len) begin
        s_data = wr_src[idx];
        case (mode)
          1: s_valid = $urandom_range(0, 9) < 7;
          2: if (idx == 2 && stall < 3) begin s_valid = 1'b0; stall++; end
             else s_valid = 1'b1;
          default: s_valid = 1'b1;
        endcase
      end else begin
        s_valid = 1'b0;
      end
      case (mode)
        1: m_ready = $urandom_range(0, 9) < 6;
        2: m_ready = (ph % 3) == 0;
        default: m_ready = 1'b1;
      endcase
      ph++;
      if (mode == 3 && !aborted && mem_enable) begin
        mem_bus_err = 1'b1;
        aborted = 1'b1;
      end else begin
        mem_bus_err = 1'b0;
      end
      #3;
      hs = s_valid && s_ready;
      got_done = done;
      got_err  = err;
      if (done || err || cyc >= 4000) break;
      @(posedge clk);
      if (hs) idx++;
      @(negedge clk);
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    mem_bus_err = 1'b0;
    check("finished_within_budget", 32'(cyc < 4000), 32'h1);
    check("done_pulse", 32'(got_done), 32'(!rej && mode != 3));
    check("err_pulse", 32'(got_err), 32'(rej || mode == 3));
    @(negedge clk);
    #3;
    bus_ok = 1'b0;
    check("pulses_one_cycle", {30'h0, done, err}, 32'h0);
    check("cmd_ready_after", 32'(cmd_ready), 32'h1);
    if (mode == 3) begin
      check("m_valid_after_abort", 32'(m_valid), 32'h0);
      exp_q.delete();
    end else begin
      check("read_beats_left", 32'(exp_q.size()), 32'h0);
      if (wr) check("write_beats_taken", 32'(idx), rej ? 32'h0 : 32'(len));
      mism = 0;
      for (int i = 0; i < 1024; i++) if (bmem[i] !== ref_mem[i]) mism++;
      check("mem_image", 32'(mism), 32'h0);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    bus_ok = 1'b0; cur_base = '0; cur_step = 32'd4; cur_wr = 1'b0; exp_be = 4'b0;
    beats = 0; en_cycles = 0;
    for (int i = 0; i < 1024; i++) begin bmem[i] = 8'h0; ref_mem[i] = 8'h0; end
    rst = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_write = 1'b0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0; mem_bus_err = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check("rst_mem_enable", 32'(mem_enable), 32'h0);
    check("rst_s_ready", 32'(s_ready), 32'h0);
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_m_data", m_data, 32'h0);
    check("rst_pulses", {30'h0, done, err}, 32'h0);
    check("rst_mem_bus", {27'h0, mem_wr_en, mem_be}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_i_data", mem_i_data, 32'h0);
    rst = 1'b0;

    // Word write, continuous stream: one run, four enabled cycles.
    wr_src = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_cmd(32'h40, 4, 2'd2, 1'b1, 0);
    check("wr_enabled_cycles", 32'(en_cycles), 32'd4);
    check("wr_run_count", 32'(run_addrs.size()), 32'd1);
    check("wr_bytes", {bmem[10'h40], bmem[10'h44], bmem[10'h48], bmem[10'h4C]}, 32'h11223344);
    check("model_word_4c", model_read(32'h4C, 4), 32'h44);

    // Word read, continuous: N+1 enabled cycles.
    run_cmd(32'h40, 4, 2'd2, 1'b0, 0);
    check("rd_enabled_cycles", 32'(en_cycles), 32'd5);
    check("rd_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4)
      check("rd_values", {got_q[0][7:0], got_q[1][7:0], got_q[2][7:0], got_q[3][7:0]}, 32'h11223344);

    // Reset in the middle of a read, then a fresh read completes.
    run_cmd(32'h40, 4, 2'd2, 1'b0, 4);
    run_cmd(32'h40, 4, 2'd2, 1'b0, 0);
    check("rd_after_reset_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) check("rd_after_reset_last", got_q[3], 32'h44);

    // Stalled write: restart at 0x48, nothing lost or duplicated.
    wr_src = '{32'h55, 32'h66, 32'h77, 32'h88};
    run_cmd(32'h40, 4, 2'd2, 1'b1, 2);
    check("stall_run_count", 32'(run_addrs.size()), 32'd2);
    if (run_addrs.size() == 2) check("stall_restart_addr", run_addrs[1], 32'h48);
    check("stall_enabled_cycles", 32'(en_cycles), 32'd4);
    check("stall_bytes", {bmem[10'h40], bmem[10'h44], bmem[10'h48], bmem[10'h4C]}, 32'h55667788);

    // Byte write with junk upper lanes, then byte read under 1,0,0 backpressure.
    wr_src.delete();
    for (int i = 0; i < 6; i++) wr_src.push_back({$urandom_range(0, 32'hFFFFFF), 8'hA1 + 8'(i)});
    run_cmd(32'h41, 6, 2'd0, 1'b1, 1);
    run_cmd(32'h41, 6, 2'd0, 1'b0, 2);
    check("bp_count", 32'(got_q.size()), 32'd6);
    check("bp_restarted", 32'(run_addrs.size() > 1), 32'h1);
    if (got_q.size() == 6) begin
      check("bp_first", got_q[0], 32'h000000A1);
      check("bp_last", got_q[5], 32'h000000A6);
    end

    // Rejections and the empty command.
    run_cmd(32'h42, 3, 2'd2, 1'b1, 0);
    check("rej_word_no_enable", 32'(en_cycles), 32'h0);
    run_cmd(32'h41, 3, 2'd1, 1'b0, 0);
    run_cmd(32'h40, 3, 2'd3, 1'b0, 0);
    run_cmd(32'h40, 0, 2'd2, 1'b1, 0);
    check("len0_no_enable", 32'(en_cycles), 32'h0);

    // Slave error aborts a read.
    run_cmd(32'h80, 8, 2'd2, 1'b0, 3);

    // Address wrap at the top of the address space.
    wr_src = '{32'h01, 32'h02, 32'h03, 32'h04};
    run_cmd(32'hFFFF_FFFE, 4, 2'd0, 1'b1, 0);
    check("wrap_bytes", {16'h0, bmem[10'h3FF], bmem[10'h000]}, 32'h0203);
    run_cmd(32'hFFFF_FFFE, 2, 2'd1, 1'b0, 0);
    check("wrap_rd_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) check("wrap_rd_second", got_q[1], 32'h0403);

    // Randomized commands, including illegal ones.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          ln;
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      ln = $urandom_range(0, 12);
      wr_src.delete();
      for (int i = 0; i < ln; i++) wr_src.push_back($urandom);
      run_cmd(a, ln, sz, 1'($urandom_range(0, 1)), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
